imgproc_sobel: RTL and testbench

- Parametrised successor to the camera-path pixel processor.
- Accepts a raster-scanned grayscale pixel stream qualified by iDVAL and tagged with iX_Cont/iY_Cont.
- Buffers two lines, forms a 3x3 window and outputs one of: delayed passthrough, |Gx|, |Gy|, or saturated |Gx|+|Gy| Sobel magnitude.
- Sits between the Bayer-to-gray stage and the VGA/SDRAM writer; drives the same value on oRed/oGreen/oBlue.

---
 rtl/imgproc_sobel.sv | 176 +++++++++++++++++
 tb/tb_imgproc_sobel.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/imgproc_sobel.sv
// imgproc_sobel: two-line-buffered 3x3 Sobel filter over a raster grayscale stream.
// Three-stage pipeline; the selected result is driven identically on oRed/oGreen/oBlue.
module imgproc_sobel #(
    parameter int unsigned DATA_WIDTH  = 12,
    parameter int unsigned LINE_WIDTH  = 1280,
    parameter int unsigned COORD_WIDTH = 16
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    input  logic [DATA_WIDTH-1:0]  iDATA,
    input  logic                   iDVAL,
    input  logic [COORD_WIDTH-1:0] iX_Cont,
    input  logic [COORD_WIDTH-1:0] iY_Cont,
    input  logic [1:0]             iMode,
    output logic [DATA_WIDTH-1:0]  oRed,
    output logic [DATA_WIDTH-1:0]  oGreen,
    output logic [DATA_WIDTH-1:0]  oBlue,
    output logic                   oDVAL,
    output logic [COORD_WIDTH-1:0] oX_Cont,
    output logic [COORD_WIDTH-1:0] oY_Cont
);

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_GX   = 2'd1,
        MODE_GY   = 2'd2,
        MODE_SUM  = 2'd3
    } mode_t;

    localparam int unsigned AW   = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int unsigned GW   = DATA_WIDTH + 3;
    localparam logic [31:0] LW32 = LINE_WIDTH;

    logic [DATA_WIDTH-1:0]  lb1 [LINE_WIDTH];
    logic [DATA_WIDTH-1:0]  lb2 [LINE_WIDTH];
    logic [DATA_WIDTH-1:0]  lb1_q, lb2_q;
    logic [AW-1:0]          lb_addr;
    logic                   in_range, accept, frame_start;

    logic [DATA_WIDTH-1:0]  p [3][3];
    logic                   primed;
    mode_t                  active_mode;

    logic                   v1, m1;
    mode_t                  mode1;
    logic [COORD_WIDTH-1:0] x1, y1;

    logic signed [GW-1:0]   gx, gy;
    logic [GW-1:0]          gx_abs, gy_abs;

    logic                   v2, m2;
    mode_t                  mode2;
    logic [COORD_WIDTH-1:0] x2, y2;
    logic [GW-1:0]          gx_q, gy_q;
    logic [DATA_WIDTH-1:0]  c2;

    logic [GW:0]            sum;
    logic [DATA_WIDTH-1:0]  res;

    function automatic logic signed [GW-1:0] wsum(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b,
                                                  input logic [DATA_WIDTH-1:0] c);
        return $signed({3'b000, a}) + $signed({2'b00, b, 1'b0}) + $signed({3'b000, c});
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sat(input logic [GW:0] v);
        return (v[GW:DATA_WIDTH] != '0) ? '1 : v[DATA_WIDTH-1:0];
    endfunction

    assign in_range    = 32'(iX_Cont) < LW32;
    assign accept      = iRST && iDVAL && in_range;
    assign frame_start = accept && (iX_Cont == '0) && (iY_Cont == '0);
    assign lb_addr     = iX_Cont[AW-1:0];
    assign lb1_q       = lb1[lb_addr];
    assign lb2_q       = lb2[lb_addr];

    // Line buffers and window carry image data only; they are never cleared.
    always_ff @(posedge iCLK) begin
        if (accept) begin
            lb1[lb_addr] <= iDATA;
            lb2[lb_addr] <= lb1_q;
            for (int unsigned r = 0; r < 3; r++) begin
                p[r][0] <= p[r][1];
                p[r][1] <= p[r][2];
            end
            p[0][2] <= lb2_q;
            p[1][2] <= lb1_q;
            p[2][2] <= iDATA;
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            primed      <= 1'b0;
            active_mode <= MODE_PASS;
            v1          <= 1'b0;
            m1          <= 1'b1;
            mode1       <= MODE_PASS;
            x1          <= '0;
            y1          <= '0;
        end else begin
            if (frame_start) begin
                primed      <= 1'b1;
                active_mode <= mode_t'(iMode);
            end
            v1    <= iDVAL;
            m1    <= !in_range || (iX_Cont < COORD_WIDTH'(2)) || (iY_Cont < COORD_WIDTH'(2))
                     || !(primed || frame_start);
            mode1 <= frame_start ? mode_t'(iMode) : active_mode;
            x1    <= iX_Cont - COORD_WIDTH'(1);
            y1    <= iY_Cont - COORD_WIDTH'(1);
        end
    end

    always_comb begin
        gx     = wsum(p[0][2], p[1][2], p[2][2]) - wsum(p[0][0], p[1][0], p[2][0]);
        gy     = wsum(p[2][0], p[2][1], p[2][2]) - wsum(p[0][0], p[0][1], p[0][2]);
        gx_abs = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
        gy_abs = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
    end

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            v2    <= 1'b0;
            m2    <= 1'b1;
            mode2 <= MODE_PASS;
            x2    <= '0;
            y2    <= '0;
            gx_q  <= '0;
            gy_q  <= '0;
            c2    <= '0;
        end else begin
            v2    <= v1;
            m2    <= m1;
            mode2 <= mode1;
            x2    <= x1;
            y2    <= y1;
            gx_q  <= gx_abs;
            gy_q  <= gy_abs;
            c2    <= p[1][1];
        end
    end

    always_comb begin
        res = '0;
        sum = {1'b0, gx_q} + {1'b0, gy_q};
        unique case (mode2)
            MODE_PASS: res = c2;
            MODE_GX:   res = sat({1'b0, gx_q});
            MODE_GY:   res = sat({1'b0, gy_q});
            MODE_SUM:  res = sat(sum);
            default:   res = '0;
        endcase
        if (m2) res = '0;
    end

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            oDVAL   <= 1'b0;
            oRed    <= '0;
            oX_Cont <= '0;
            oY_Cont <= '0;
        end else begin
            oDVAL <= v2;
            if (v2) begin
                oRed    <= res;
                oX_Cont <= x2;
                oY_Cont <= y2;
            end
        end
    end

    assign oGreen = oRed;
    assign oBlue  = oRed;

endmodule

// File: tb/tb_imgproc_sobel.sv
// Directed bench for imgproc_sobel: small 16x5 frames of hand-analysed patterns,
// expected results queued per pixel and checked three cycles later.
module tb_imgproc_sobel;

    localparam int DW = 12;
    localparam int LW = 1280;
    localparam int CW = 16;
    localparam int W  = 16;
    localparam int H  = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] data;
    logic          dval;
    logic [CW-1:0] xc, yc;
    logic [1:0]    mode;
    logic [DW-1:0] o_r, o_g, o_b;
    logic          o_dval;
    logic [CW-1:0] o_x, o_y;

    always #5 clk = ~clk;

    imgproc_sobel #(.DATA_WIDTH(DW), .LINE_WIDTH(LW), .COORD_WIDTH(CW)) dut (
        .iCLK(clk), .iRST(rst_n), .iDATA(data), .iDVAL(dval),
        .iX_Cont(xc), .iY_Cont(yc), .iMode(mode),
        .oRed(o_r), .oGreen(o_g), .oBlue(o_b), .oDVAL(o_dval),
        .oX_Cont(o_x), .oY_Cont(o_y)
    );

    typedef struct {
        int            due;
        logic [DW-1:0] val;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } exp_t;

    exp_t          q[$];
    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    bit            chk_en = 1'b0;
    logic [DW-1:0] last_val = '0;
    logic [CW-1:0] last_x = '0;
    logic [CW-1:0] last_y = '0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    always @(negedge clk) begin : checker_p
        exp_t e;
        if (chk_en) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("odval", 32'(o_dval), 32'd1);
                chk("ored", 32'(o_r), 32'(e.val));
                chk("ogreen", 32'(o_g), 32'(e.val));
                chk("oblue", 32'(o_b), 32'(e.val));
                chk("ox", 32'(o_x), 32'(e.x));
                chk("oy", 32'(o_y), 32'(e.y));
                last_val = e.val;
                last_x   = e.x;
                last_y   = e.y;
            end else begin
                chk("odval_idle", 32'(o_dval), 32'd0);
                chk("hold_red", 32'(o_r), 32'(last_val));
                chk("hold_x", 32'(o_x), 32'(last_x));
                chk("hold_y", 32'(o_y), 32'(last_y));
            end
        end
    end

    function automatic logic [DW-1:0] pix(input int pat, input int x, input int y);
        int v;
        case (pat)
            0:       v = 100;
            1:       v = (x < 8) ? 0 : 1000;
            2:       v = (x < 8) ? 0 : 4095;
            default: v = (y < 3) ? 0 : 500;
        endcase
        return DW'(v);
    endfunction

    function automatic logic [DW-1:0] sat(input int v);
        logic [31:0] u;
        u = v;
        return (v > ((1 << DW) - 1)) ? '1 : u[DW-1:0];
    endfunction

    // Closed-form expectations: vertical edge at x=8 lights inputs x=8,9 (|Gx|=4v);
    // horizontal edge at y=3 lights rows 3,4 (|Gy|=2000); passthrough is the pixel at (x-1,y-1).
    function automatic logic [DW-1:0] exp_val(input int pat, input int emode, input int x,
                                              input int y, input bit primed);
        int gx, gy, p11, r, v;
        gx = 0; gy = 0; p11 = 0;
        if (!primed || x < 2 || y < 2) return '0;
        case (pat)
            0: p11 = 100;
            1, 2: begin
                v   = (pat == 1) ? 1000 : 4095;
                gx  = (x == 8 || x == 9) ? 4 * v : 0;
                p11 = (x >= 9) ? v : 0;
            end
            default: begin
                gy  = (y == 3 || y == 4) ? 2000 : 0;
                p11 = (y >= 4) ? 500 : 0;
            end
        endcase
        case (emode)
            0:       r = p11;
            1:       r = gx;
            2:       r = gy;
            default: r = gx + gy;
        endcase
        return sat(r);
    endfunction

    task automatic drive(input logic d_v, input logic [CW-1:0] x, input logic [CW-1:0] y,
                         input logic [DW-1:0] d, input logic [1:0] m, input logic [DW-1:0] expv);
        logic [CW-1:0] xm, ym;
        @(posedge clk); #2;
        dval = d_v; xc = x; yc = y; data = d; mode = m;
        xm = x - 16'd1;
        ym = y - 16'd1;
        if (d_v) q.push_back('{cyc + 3, expv, xm, ym});
    endtask

    task automatic run_row(input int pat, input int y, input logic [1:0] m, input int emode,
                           input bit primed, input int x_from, input int x_to, input bit idle);
        for (int x = x_from; x <= x_to; x++)
            drive(1'b1, CW'(x), CW'(y), pix(pat, x, y), m, exp_val(pat, emode, x, y, primed));
        if (idle) drive(1'b0, 16'd3, 16'd3, DW'($urandom), 2'd3, '0);
    endtask

    task automatic run_frame(input int pat, input logic [1:0] m0, input logic [1:0] m1,
                             input int sw_row, input int emode);
        for (int y = 0; y < H; y++)
            run_row(pat, y, (y >= sw_row) ? m1 : m0, emode, 1'b1, 0, W - 1, 1'b1);
    endtask

    task automatic pulse_reset(input logic [CW-1:0] x, input logic [CW-1:0] y,
                               input logic [DW-1:0] d, input logic [1:0] m);
        @(posedge clk); #2;
        rst_n = 1'b0; dval = 1'b1; xc = x; yc = y; data = d; mode = m;
        @(posedge clk); #2;
        q.delete();
        last_val = '0; last_x = '0; last_y = '0;
        rst_n = 1'b1; dval = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; dval = 1'b0; data = '0; xc = '0; yc = '0; mode = 2'd0;
        @(posedge clk); #2;
        chk_en = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Before any frame start every result is masked.
        run_row(0, 7, 2'd0, 0, 1'b0, 2, 5, 1'b1);

        run_frame(0, 2'd3, 2'd3, H, 3);
        run_frame(0, 2'd0, 2'd0, H, 0);

        // Vertical edge, mode 1, with two out-of-range pixels spliced into row 2.
        run_row(1, 0, 2'd1, 1, 1'b1, 0, W - 1, 1'b1);
        run_row(1, 1, 2'd1, 1, 1'b1, 0, W - 1, 1'b1);
        run_row(1, 2, 2'd1, 1, 1'b1, 0, 8, 1'b0);
        drive(1'b1, 16'd1280, 16'd2, 12'd4095, 2'd1, 12'd0);
        drive(1'b1, 16'd2056, 16'd2, 12'd4095, 2'd1, 12'd0);
        run_row(1, 2, 2'd1, 1, 1'b1, 9, W - 1, 1'b1);
        run_row(1, 3, 2'd1, 1, 1'b1, 0, W - 1, 1'b1);
        run_row(1, 4, 2'd1, 1, 1'b1, 0, W - 1, 1'b1);

        run_frame(1, 2'd2, 2'd2, H, 2);
        run_frame(2, 2'd3, 2'd3, H, 3);

        // Mode switch 1->2 mid-frame is deferred to the next frame start.
        run_frame(1, 2'd1, 2'd2, 2, 1);
        run_frame(1, 2'd2, 2'd2, H, 2);

        run_frame(3, 2'd2, 2'd2, H, 2);
        run_frame(3, 2'd3, 2'd3, H, 3);
        run_frame(3, 2'd1, 2'd1, H, 1);

        // Mid-frame reset: in-flight results dropped, masked until the next (0,0).
        run_row(1, 0, 2'd1, 1, 1'b1, 0, W - 1, 1'b1);
        run_row(1, 1, 2'd1, 1, 1'b1, 0, W - 1, 1'b1);
        run_row(1, 2, 2'd1, 1, 1'b1, 0, W - 1, 1'b1);
        run_row(1, 3, 2'd1, 1, 1'b1, 0, 9, 1'b0);
        pulse_reset(16'd10, 16'd3, 12'd4095, 2'd2);
        run_row(1, 3, 2'd1, 1, 1'b0, 11, W - 1, 1'b1);
        run_row(1, 4, 2'd1, 1, 1'b0, 0, W - 1, 1'b1);
        run_frame(1, 2'd1, 2'd1, H, 1);

        for (int i = 0; i < 6; i++) drive(1'b0, 16'd0, 16'd0, '0, 2'd0, '0);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
